// File: rtl/writeback.sv
// ----------------------------------------------------------------------------
// writeback: final stage of the multi-cycle core.
// Accepts one completed instruction from execute per handshake, picks the ALU
// or memory result, pulses a single-cycle register-file write, then signals
// retirement to fetch and waits for it to be accepted.
//
// Ports:
//   clock, reset               clock, synchronous active-high reset
//   valid_pre_i / ready_pre_o  handshake with execute
//   valid_post_o / ready_post_i retirement handshake with fetch
//   wsel_i, wena_i, waddr_i,
//   alu_result_i, mem_result_i instruction payload from execute
//   wena_o, waddr_o, wdata_o   register-file write port
//   minstret_o                 retired-instruction count (WBU_RETIRE_CNT_EN)
//
// Optional feature macro: WBU_RETIRE_CNT_EN adds the 64-bit minstret counter.
// ----------------------------------------------------------------------------
module writeback #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned REG_DW = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              valid_pre_i,
   output logic              ready_pre_o,
   output logic              valid_post_o,
   input  logic              ready_post_i,
   input  logic              wsel_i,
   input  logic              wena_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [REG_DW-1:0] alu_result_i,
   input  logic [REG_DW-1:0] mem_result_i,
   output logic              wena_o,
   output logic [REG_AW-1:0] waddr_o,
   output logic [REG_DW-1:0] wdata_o
`ifdef WBU_RETIRE_CNT_EN
   ,
   output logic [63:0]       minstret_o
`endif
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WRITE   = 2'd1;
   localparam logic [1:0] S_RETIRE  = 2'd2;
   localparam logic [1:0] S_ILLEGAL = 2'd3;

   logic [1:0]        state;
   logic [1:0]        state_d;
   logic              load;

   logic              wsel_q;
   logic              wena_q;
   logic [REG_AW-1:0] waddr_q;
   logic [REG_DW-1:0] alu_q;
   logic [REG_DW-1:0] mem_q;

   // Next-state logic; load marks the IDLE acceptance handshake.
   always_comb begin
      state_d = state;
      load    = 1'b0;
      case (state)
         S_IDLE: begin
            if (valid_pre_i) begin
               load    = 1'b1;
               state_d = S_WRITE;
            end
         end
         S_WRITE:   state_d = S_RETIRE;
         S_RETIRE: begin
            if (ready_post_i) state_d = S_IDLE;
         end
         S_ILLEGAL: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_d;
   end

   // Instruction latch: loads only on the acceptance handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         wsel_q  <= 1'b0;
         wena_q  <= 1'b0;
         waddr_q <= '0;
         alu_q   <= '0;
         mem_q   <= '0;
      end else if (load) begin
         wsel_q  <= wsel_i;
         wena_q  <= wena_i;
         waddr_q <= waddr_i;
         alu_q   <= alu_result_i;
         mem_q   <= mem_result_i;
      end
   end

   // Outputs decode the state register only; the illegal encoding asserts nothing.
   assign ready_pre_o  = (state == S_IDLE);
   assign valid_post_o = (state == S_RETIRE);
   // x0 is hardwired to zero, so writes to it are dropped here.
   assign wena_o       = (state == S_WRITE) && wena_q && (waddr_q != '0);
   assign waddr_o      = waddr_q;
   assign wdata_o      = wsel_q ? mem_q : alu_q;

`ifdef WBU_RETIRE_CNT_EN
   logic [63:0] minstret_q;

   // Counts every accepted retirement; wraps naturally at 2^64.
   always_ff @(posedge clock) begin
      if (reset)                             minstret_q <= '0;
      else if (valid_post_o && ready_post_i) minstret_q <= minstret_q + 64'd1;
   end

   assign minstret_o = minstret_q;
`endif

endmodule

// File: tb/tb_writeback.sv
// ----------------------------------------------------------------------------
// tb_writeback: randomized plus directed bench for writeback, checked against a
// transaction-level model (in-flight flag, acceptance cycle, selected data).
// ----------------------------------------------------------------------------
module tb_writeback;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          valid_pre_i;
   logic          ready_pre_o;
   logic          valid_post_o;
   logic          ready_post_i;
   logic          wsel_i;
   logic          wena_i;
   logic [AW-1:0] waddr_i;
   logic [DW-1:0] alu_result_i;
   logic [DW-1:0] mem_result_i;
   logic          wena_o;
   logic [AW-1:0] waddr_o;
   logic [DW-1:0] wdata_o;
`ifdef WBU_RETIRE_CNT_EN
   logic [63:0]   minstret_o;
`endif

   writeback #(.REG_AW(AW), .REG_DW(DW)) dut (
      .clock        (clock),
      .reset        (reset),
      .valid_pre_i  (valid_pre_i),
      .ready_pre_o  (ready_pre_o),
      .valid_post_o (valid_post_o),
      .ready_post_i (ready_post_i),
      .wsel_i       (wsel_i),
      .wena_i       (wena_i),
      .waddr_i      (waddr_i),
      .alu_result_i (alu_result_i),
      .mem_result_i (mem_result_i),
      .wena_o       (wena_o),
      .waddr_o      (waddr_o),
      .wdata_o      (wdata_o)
`ifdef WBU_RETIRE_CNT_EN
      ,
      .minstret_o   (minstret_o)
`endif
   );

   always #5 clock = ~clock;

   // Reference model state.
   bit            inflight;
   int unsigned   cyc;
   int unsigned   acc_cyc;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   bit            m_we;
   logic [63:0]   m_cnt;
   int unsigned   n_acc;
   int unsigned   n_wena;

   int unsigned   n_cmp;
   int unsigned   n_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Called at a negedge: check outputs, drive inputs, advance one clock.
   task automatic step(input bit rst, input bit v, input bit rp, input bit ws, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] alu, input logic [DW-1:0] mem);
      bit exp_wena;
      bit exp_vp;
      exp_wena = inflight && (cyc == acc_cyc) && m_we && (m_addr != '0);
      exp_vp   = inflight && (cyc >= acc_cyc + 1);
      check("ready_pre",  64'(ready_pre_o),  64'(!inflight));
      check("valid_post", 64'(valid_post_o), 64'(exp_vp));
      check("wena",       64'(wena_o),       64'(exp_wena));
      check("waddr",      64'(waddr_o),      64'(m_addr));
      check("wdata",      64'(wdata_o),      64'(m_data));
`ifdef WBU_RETIRE_CNT_EN
      check("minstret",   minstret_o,        m_cnt);
`endif
      if (wena_o) n_wena++;
      reset        = rst;
      valid_pre_i  = v;
      ready_post_i = rp;
      wsel_i       = ws;
      wena_i       = we;
      waddr_i      = a;
      alu_result_i = alu;
      mem_result_i = mem;
      @(posedge clock);
      cyc++;
      if (rst) begin
         inflight = 1'b0;
         m_addr   = '0;
         m_data   = '0;
         m_we     = 1'b0;
         m_cnt    = '0;
      end else if (!inflight && v) begin
         inflight = 1'b1;
         acc_cyc  = cyc;
         m_addr   = a;
         m_data   = ws ? mem : alu;
         m_we     = we;
         n_acc++;
      end else if (exp_vp && rp) begin
         inflight = 1'b0;
         m_cnt    = m_cnt + 64'd1;
      end
      @(negedge clock);
   endtask

   task automatic idle(input int unsigned n);
      for (int i = 0; i < int'(n); i++) step(0, 0, 1, 0, 0, '0, '0, '0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0; acc_cyc = 0; n_acc = 0; n_wena = 0;
      reset = 1'b1; valid_pre_i = 1'b0; ready_post_i = 1'b0; wsel_i = 1'b0;
      wena_i = 1'b0; waddr_i = '0; alu_result_i = '0; mem_result_i = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      inflight = 1'b0; m_addr = '0; m_data = '0; m_we = 1'b0; m_cnt = '0;

      // Reset state, then ALU write to x5.
      step(0, 1, 1, 0, 1, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF);
      check("alu_wena_pulse", 64'(wena_o), 64'd1);
      check("alu_wdata", 64'(wdata_o), 64'h1234_5678);
      idle(3);

      // Load write to x7, then same to x0 (suppressed, still retires).
      step(0, 1, 1, 1, 1, 5'd7, 32'h0, 32'hCAFE_F00D);
      check("load_wdata", 64'(wdata_o), 64'hCAFE_F00D);
      idle(3);
      n_wena = 0;
      step(0, 1, 1, 1, 1, 5'd0, 32'h0, 32'hCAFE_F00D);
      idle(3);
      check("x0_no_write", 64'(n_wena), 64'd0);

      // Backpressure: retire held off, new valid_pre ignored.
      n_wena = 0;
      step(0, 1, 0, 0, 1, 5'd9, 32'h0000_00A5, 32'h0);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 1, 1, 5'd3, 32'h1, 32'h2);
      step(0, 0, 1, 0, 0, '0, '0, '0);
      idle(2);
      check("bp_single_wena", 64'(n_wena), 64'd1);

      // Reset while in WRITE.
      step(0, 1, 1, 0, 1, 5'd11, 32'h5555_AAAA, 32'h0);
      step(1, 0, 1, 0, 0, '0, '0, '0);
      check("rst_mid_wdata", 64'(wdata_o), 64'd0);
      idle(3);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(0, 79) == 0), 1'($urandom), ($urandom_range(0, 2) != 0),
              1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
      idle(4);

`ifdef WBU_RETIRE_CNT_EN
      // Ten back-to-back instructions, three without a GPR write.
      step(1, 0, 1, 0, 0, '0, '0, '0);
      n_acc = 0;
      for (int i = 0; i < 40; i++)
         step(0, (n_acc < 10), 1, 1'($urandom), (n_acc >= 3), AW'($urandom), DW'($urandom), DW'($urandom));
      check("minstret_ten", minstret_o, 64'd10);

      // Wrap from all-ones to zero.
      force dut.minstret_q = '1;
      #1 release dut.minstret_q;
      m_cnt = '1;
      step(0, 1, 1, 0, 1, 5'd1, 32'h1, 32'h0);
      idle(3);
      check("minstret_wrap", minstret_o, 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
